// File: rtl/lsu_iq_gen_pkg.sv
// Shared types for the LSU issue queue: uop payload, physical register tag,
// queue entry record and the per-slot update selector.
package lsu_iq_gen_pkg;

    localparam int unsigned PRF_W = 6;
    localparam int unsigned ROB_W = 6;

    typedef logic [PRF_W-1:0] PRFNum;

    typedef struct packed {
        logic [ROB_W-1:0] rob_idx;
        PRFNum            pdst;
        PRFNum            op0PAddr;
        PRFNum            op1PAddr;
    } UOPBundle;

    typedef struct packed {
        UOPBundle uop;
        logic     rdy0;
        logic     rdy1;
        logic     is_store;
        logic     valid;
    } iq_entry_t;

    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_SHIFT,
        SLOT_ENQ,
        SLOT_CLEAR
    } slot_op_e;

endpackage

// File: rtl/lsu_iq_slot.sv
// One issue-queue entry: picks hold/shift-down/enqueue/clear, then applies
// wakeup matches to whichever candidate lands in the register.
module lsu_iq_slot
    import lsu_iq_gen_pkg::*;
#(
    parameter int unsigned WAKE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  slot_op_e          op_i,
    input  iq_entry_t         up_entry_i,
    input  iq_entry_t         enq_entry_i,
    input  logic [WAKE_W-1:0] wake_valid_i,
    input  PRFNum [WAKE_W-1:0] wake_preg_i,
    output iq_entry_t         entry_o
);

    iq_entry_t entry_q;
    iq_entry_t entry_d;
    iq_entry_t cand;
    logic      hit0;
    logic      hit1;

    always_comb begin
        cand = entry_q;
        case (op_i)
            SLOT_SHIFT: cand = up_entry_i;
            SLOT_ENQ:   cand = enq_entry_i;
            SLOT_CLEAR: cand = '0;
            default:    cand = entry_q;
        endcase

        hit0 = 1'b0;
        hit1 = 1'b0;
        for (int j = 0; j < int'(WAKE_W); j++) begin
            if (wake_valid_i[j] && (wake_preg_i[j] == cand.uop.op0PAddr)) hit0 = 1'b1;
            if (wake_valid_i[j] && (wake_preg_i[j] == cand.uop.op1PAddr)) hit1 = 1'b1;
        end

        entry_d      = cand;
        entry_d.rdy0 = cand.rdy0 | (cand.valid & hit0);
        entry_d.rdy1 = cand.rdy1 | (cand.valid & hit1);
    end

    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/lsu_iq_gen.sv
// Age-ordered, compacting LSU issue queue with wakeup, store-barrier or
// in-order select, and same-cycle enqueue + issue.
module lsu_iq_gen
    import lsu_iq_gen_pkg::*;
#(
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned ENQ_W      = 2,
    parameter  int unsigned WAKE_W     = 4,
    parameter  int unsigned ORDER_MODE = 0,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ENQ_W-1:0]      enq_valid,
    input  UOPBundle [ENQ_W-1:0]  enq_uop,
    input  logic [ENQ_W-1:0][1:0] enq_src_rdy,
    input  logic [ENQ_W-1:0]      enq_is_store,
    output logic                  enq_ready,
    input  logic [WAKE_W-1:0]     wake_valid,
    input  PRFNum [WAKE_W-1:0]    wake_preg,
    input  logic                  lsu_busy,
    output logic                  issue_valid,
    output UOPBundle              issue_uop,
    output logic [CNT_W-1:0]      count
);

    iq_entry_t        entries      [DEPTH];
    iq_entry_t        up_entries   [DEPTH];
    iq_entry_t        slot_enq     [DEPTH];
    slot_op_e         slot_op      [DEPTH];
    iq_entry_t        lane_by_rank [ENQ_W];
    int               lane_rank    [ENQ_W];
    int               n_enq;
    int               base_idx;
    logic [DEPTH-1:0] elig;
    logic             older_store;
    logic [IDX_W-1:0] issue_idx;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count     = count_q;
    assign enq_ready = (32'(DEPTH) - 32'(count_q)) >= 32'(ENQ_W);

    // Oldest eligible entry wins; a valid older store blocks everything behind it.
    always_comb begin
        older_store = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            elig[i] = entries[i].valid && entries[i].rdy0 && entries[i].rdy1 && !lsu_busy &&
                      ((ORDER_MODE == 1) ? (i == 0) : !older_store);
            older_store = older_store | (entries[i].valid & entries[i].is_store);
        end
        issue_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (elig[i]) issue_idx = IDX_W'(i);
        end
        issue_valid = |elig;
        issue_uop   = issue_valid ? entries[issue_idx].uop : '0;
    end

    // Squeeze valid lanes into rank order so they land contiguously.
    always_comb begin
        n_enq = 0;
        for (int l = 0; l < int'(ENQ_W); l++) begin
            lane_rank[l] = n_enq;
            if (enq_valid[l]) n_enq = n_enq + 1;
        end
        for (int r = 0; r < int'(ENQ_W); r++) begin
            lane_by_rank[r] = '0;
            for (int l = 0; l < int'(ENQ_W); l++) begin
                if (enq_valid[l] && (lane_rank[l] == r)) begin
                    lane_by_rank[r].uop      = enq_uop[l];
                    lane_by_rank[r].rdy0     = enq_src_rdy[l][0];
                    lane_by_rank[r].rdy1     = enq_src_rdy[l][1];
                    lane_by_rank[r].is_store = enq_is_store[l];
                    lane_by_rank[r].valid    = 1'b1;
                end
            end
        end
        if (!enq_ready) n_enq = 0;
    end

    // base_idx is the post-issue occupancy: entries above the issued one shift
    // down below it, new ops append from it, and everything past is cleared.
    always_comb begin
        base_idx = int'(count_q) - (issue_valid ? 1 : 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_op[i]  = SLOT_HOLD;
            slot_enq[i] = '0;
            if (flush) begin
                slot_op[i] = SLOT_CLEAR;
            end else if (issue_valid && (i >= int'(issue_idx)) && (i < base_idx)) begin
                slot_op[i] = SLOT_SHIFT;
            end else if ((i >= base_idx) && (i < base_idx + n_enq)) begin
                slot_op[i] = SLOT_ENQ;
                for (int r = 0; r < int'(ENQ_W); r++) begin
                    if (i == base_idx + r) slot_enq[i] = lane_by_rank[r];
                end
            end else if (i >= base_idx) begin
                slot_op[i] = SLOT_CLEAR;
            end
        end
        count_d = flush ? '0 : CNT_W'(base_idx + n_enq);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slot
        if (g == int'(DEPTH) - 1) begin : g_top
            assign up_entries[g] = '0;
        end else begin : g_mid
            assign up_entries[g] = entries[g+1];
        end

        lsu_iq_slot #(
            .WAKE_W (WAKE_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .op_i         (slot_op[g]),
            .up_entry_i   (up_entries[g]),
            .enq_entry_i  (slot_enq[g]),
            .wake_valid_i (wake_valid),
            .wake_preg_i  (wake_preg),
            .entry_o      (entries[g])
        );
    end

endmodule

// File: tb/tb_lsu_iq_gen.sv
// Scenario bench for lsu_iq_gen (DEPTH=8, ENQ_W=2, WAKE_W=4, ORDER_MODE=0);
// expected issue order is queued as stimulus is driven and popped on issue.
module tb_lsu_iq_gen;
    import lsu_iq_gen_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      enq_valid;
    UOPBundle [1:0]  enq_uop;
    logic [1:0][1:0] enq_src_rdy;
    logic [1:0]      enq_is_store;
    logic            enq_ready;
    logic [3:0]      wake_valid;
    PRFNum [3:0]     wake_preg;
    logic            lsu_busy;
    logic            issue_valid;
    UOPBundle        issue_uop;
    logic [3:0]      count;

    UOPBundle exp_q[$];
    UOPBundle exp_u;
    int       n_checks = 0;
    int       n_pass   = 0;

    always #5 clk = ~clk;

    lsu_iq_gen #(
        .DEPTH      (8),
        .ENQ_W      (2),
        .WAKE_W     (4),
        .ORDER_MODE (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_uop      (enq_uop),
        .enq_src_rdy  (enq_src_rdy),
        .enq_is_store (enq_is_store),
        .enq_ready    (enq_ready),
        .wake_valid   (wake_valid),
        .wake_preg    (wake_preg),
        .lsu_busy     (lsu_busy),
        .issue_valid  (issue_valid),
        .issue_uop    (issue_uop),
        .count        (count)
    );

    function automatic UOPBundle mk(input int r, input int a, input int b);
        UOPBundle u;
        u.rob_idx  = 6'(r);
        u.pdst     = 6'(r + 1);
        u.op0PAddr = 6'(a);
        u.op1PAddr = 6'(b);
        return u;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        enq_valid    = '0;
        enq_uop      = '0;
        enq_src_rdy  = '0;
        enq_is_store = '0;
        wake_valid   = '0;
        wake_preg    = '0;
        flush        = 1'b0;
        lsu_busy     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %0b expected 1", enq_ready); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %0b expected 0", issue_valid); else n_pass++;
        n_checks++; if (issue_uop !== '0) $display("FAIL reset_issue_uop: got %h expected 0", issue_uop); else n_pass++;
    endtask

    task automatic test_basic();
        enq_valid   = 2'b11;
        enq_uop[0]  = mk(1, 1, 2);
        enq_uop[1]  = mk(2, 3, 4);
        enq_src_rdy = 4'b1111;
        exp_q.push_back(enq_uop[0]);
        exp_q.push_back(enq_uop[1]);
        #1;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL basic_empty_issue: got %0b expected 0", issue_valid); else n_pass++;
        cyc();
        drive_idle();
        #1;
        n_checks++; if (count !== 4'd2) $display("FAIL basic_count2: got %0d expected 2", count); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL basic_issue%0d: valid=%0b expected 1", k, issue_valid);
            else begin
                exp_u = exp_q.pop_front();
                if (issue_uop !== exp_u) $display("FAIL basic_issue%0d: uop=%h expected %h", k, issue_uop, exp_u); else n_pass++;
            end
            cyc();
            n_checks++; if (count !== 4'(1 - k)) $display("FAIL basic_count_after%0d: got %0d expected %0d", k, count, 1 - k); else n_pass++;
        end
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL basic_drained: got %0b expected 0", issue_valid); else n_pass++;
    endtask

    task automatic test_wakeup();
        enq_valid   = 2'b01;
        enq_uop[0]  = mk(3, 12, 5);
        enq_src_rdy = 4'b0010;
        exp_q.push_back(enq_uop[0]);
        cyc();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_early%0d: got %0b expected 0", k, issue_valid); else n_pass++;
            cyc();
        end
        wake_valid   = 4'b0100;
        wake_preg[2] = 6'd12;
        #1;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_same_cycle: got %0b expected 0", issue_valid); else n_pass++;
        cyc();
        drive_idle();
        #1;
        n_checks++;
        if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL wake_issue: valid=%0b expected 1", issue_valid);
        else begin
            exp_u = exp_q.pop_front();
            if (issue_uop !== exp_u) $display("FAIL wake_issue: uop=%h expected %h", issue_uop, exp_u); else n_pass++;
        end
        cyc();
        n_checks++; if (count !== 4'd0) $display("FAIL wake_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_store_barrier();
        enq_valid      = 2'b11;
        enq_uop[0]     = mk(4, 20, 6);
        enq_uop[1]     = mk(5, 7, 8);
        enq_src_rdy[0] = 2'b10;
        enq_src_rdy[1] = 2'b11;
        enq_is_store   = 2'b01;
        exp_q.push_back(enq_uop[0]);
        exp_q.push_back(enq_uop[1]);
        cyc();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (issue_valid !== 1'b0) $display("FAIL store_blocked%0d: got %0b expected 0", k, issue_valid); else n_pass++;
            cyc();
        end
        wake_valid   = 4'b0001;
        wake_preg[0] = 6'd20;
        #1;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL store_wake_cycle: got %0b expected 0", issue_valid); else n_pass++;
        cyc();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL store_issue%0d: valid=%0b expected 1", k, issue_valid);
            else begin
                exp_u = exp_q.pop_front();
                if (issue_uop !== exp_u) $display("FAIL store_issue%0d: uop=%h expected %h", k, issue_uop, exp_u); else n_pass++;
            end
            cyc();
        end
        n_checks++; if (count !== 4'd0) $display("FAIL store_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_full();
        lsu_busy    = 1'b1;
        enq_src_rdy = 4'b1111;
        for (int b = 0; b < 3; b++) begin
            enq_valid  = 2'b11;
            enq_uop[0] = mk(10 + 2 * b, 1, 1);
            enq_uop[1] = mk(11 + 2 * b, 2, 2);
            exp_q.push_back(enq_uop[0]);
            exp_q.push_back(enq_uop[1]);
            cyc();
        end
        enq_valid  = 2'b01;
        enq_uop[0] = mk(16, 3, 3);
        exp_q.push_back(enq_uop[0]);
        cyc();
        enq_valid = 2'b00;
        #1;
        n_checks++; if (count !== 4'd7) $display("FAIL full_count7: got %0d expected 7", count); else n_pass++;
        n_checks++; if (enq_ready !== 1'b0) $display("FAIL full_enq_ready: got %0b expected 0", enq_ready); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL full_busy_issue: got %0b expected 0", issue_valid); else n_pass++;
        enq_valid  = 2'b11;
        enq_uop[0] = mk(20, 4, 4);
        enq_uop[1] = mk(21, 5, 5);
        cyc();
        enq_valid = 2'b00;
        #1;
        n_checks++; if (count !== 4'd7) $display("FAIL full_dropped_count: got %0d expected 7", count); else n_pass++;
        lsu_busy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_checks++;
            if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL full_issue%0d: valid=%0b expected 1", k, issue_valid);
            else begin
                exp_u = exp_q.pop_front();
                if (issue_uop !== exp_u) $display("FAIL full_issue%0d: uop=%h expected %h", k, issue_uop, exp_u); else n_pass++;
            end
            cyc();
            if (k == 0) begin
                n_checks++; if (count !== 4'd6) $display("FAIL full_count6: got %0d expected 6", count); else n_pass++;
                n_checks++; if (enq_ready !== 1'b1) $display("FAIL full_enq_ready6: got %0b expected 1", enq_ready); else n_pass++;
            end
        end
        n_checks++; if (count !== 4'd0) $display("FAIL full_drained: got %0d expected 0", count); else n_pass++;
        drive_idle();
    endtask

    task automatic test_enq_issue();
        lsu_busy       = 1'b1;
        enq_valid      = 2'b11;
        enq_uop[0]     = mk(30, 40, 9);
        enq_uop[1]     = mk(31, 1, 2);
        enq_src_rdy[0] = 2'b10;
        enq_src_rdy[1] = 2'b11;
        exp_q.push_back(enq_uop[1]);
        cyc();
        enq_uop[0]  = mk(32, 1, 2);
        enq_uop[1]  = mk(33, 1, 2);
        enq_src_rdy = 4'b1111;
        exp_q.push_back(enq_uop[0]);
        exp_q.push_back(enq_uop[1]);
        cyc();
        enq_valid = 2'b00;
        #1;
        n_checks++; if (count !== 4'd4) $display("FAIL ei_count4: got %0d expected 4", count); else n_pass++;
        lsu_busy   = 1'b0;
        enq_valid  = 2'b11;
        enq_uop[0] = mk(34, 1, 2);
        enq_uop[1] = mk(35, 1, 2);
        exp_q.push_back(enq_uop[0]);
        exp_q.push_back(enq_uop[1]);
        #1;
        n_checks++;
        if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ei_issue_idx1: valid=%0b expected 1", issue_valid);
        else begin
            exp_u = exp_q.pop_front();
            if (issue_uop !== exp_u) $display("FAIL ei_issue_idx1: uop=%h expected %h", issue_uop, exp_u); else n_pass++;
        end
        cyc();
        enq_valid = 2'b00;
        #1;
        n_checks++; if (count !== 4'd5) $display("FAIL ei_count5: got %0d expected 5", count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ei_order%0d: valid=%0b expected 1", k, issue_valid);
            else begin
                exp_u = exp_q.pop_front();
                if (issue_uop !== exp_u) $display("FAIL ei_order%0d: uop=%h expected %h", k, issue_uop, exp_u); else n_pass++;
            end
            cyc();
        end
        n_checks++; if (count !== 4'd1) $display("FAIL ei_count1: got %0d expected 1", count); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL ei_head_blocked: got %0b expected 0", issue_valid); else n_pass++;
        wake_valid   = 4'b0010;
        wake_preg[1] = 6'd40;
        exp_q.push_back(mk(30, 40, 9));
        cyc();
        drive_idle();
        #1;
        n_checks++;
        if (issue_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ei_head_issue: valid=%0b expected 1", issue_valid);
        else begin
            exp_u = exp_q.pop_front();
            if (issue_uop !== exp_u) $display("FAIL ei_head_issue: uop=%h expected %h", issue_uop, exp_u); else n_pass++;
        end
        cyc();
        n_checks++; if (count !== 4'd0) $display("FAIL ei_count0: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_flush();
        lsu_busy    = 1'b1;
        enq_valid   = 2'b11;
        enq_uop[0]  = mk(50, 1, 2);
        enq_uop[1]  = mk(51, 1, 2);
        enq_src_rdy = 4'b1111;
        cyc();
        enq_valid = 2'b00;
        #1;
        n_checks++; if (count !== 4'd2) $display("FAIL flush_pre_count: got %0d expected 2", count); else n_pass++;
        flush      = 1'b1;
        lsu_busy   = 1'b0;
        enq_valid  = 2'b11;
        enq_uop[0] = mk(52, 1, 2);
        enq_uop[1] = mk(53, 1, 2);
        #1;
        n_checks++; if (issue_valid !== 1'b1) $display("FAIL flush_cycle_issue: got %0b expected 1", issue_valid); else n_pass++;
        cyc();
        drive_idle();
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL flush_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL flush_issue: got %0b expected 0", issue_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        lsu_busy    = 1'b1;
        enq_valid   = 2'b11;
        enq_uop[0]  = mk(60, 1, 2);
        enq_uop[1]  = mk(61, 1, 2);
        enq_src_rdy = 4'b1111;
        cyc();
        rst        = 1'b1;
        flush      = 1'b1;
        lsu_busy   = 1'b0;
        enq_uop[0] = mk(62, 1, 2);
        enq_uop[1] = mk(63, 1, 2);
        cyc();
        rst = 1'b0;
        drive_idle();
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL rstmid_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL rstmid_issue: got %0b expected 0", issue_valid); else n_pass++;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL rstmid_enq_ready: got %0b expected 1", enq_ready); else n_pass++;
        n_checks++; if (issue_uop !== '0) $display("FAIL rstmid_uop: got %h expected 0", issue_uop); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_basic();
        test_wakeup();
        test_store_barrier();
        test_full();
        test_enq_issue();
        test_flush();
        test_reset_mid();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_iq_gen.md
LSU_IQ_GEN -- requirements
Module: lsu_iq_gen

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of queue entries (4..16).
REQ-002 SHALL provide parameter ENQ_W, default 2, dispatch lanes per cycle (1..4).
REQ-003 SHALL provide parameter WAKE_W, default 4, wakeup broadcast ports.
REQ-004 SHALL provide parameter ORDER_MODE, default 0: 0 = stores act as barriers; 1 = strict in-order issue.
REQ-005 SHALL provide port clk  in  1  clock; reset rst, synchronous, active-high.
REQ-006 SHALL provide port flush  in  1  clears all entries.
REQ-007 SHALL provide port enq_valid  in  ENQ_W  per-lane dispatch request.
REQ-008 SHALL provide port enq_uop  in  ENQ_W x UOPBundle  per-lane payload (op0PAddr, op1PAddr used as sources).
REQ-009 SHALL provide port enq_src_rdy  in  ENQ_W x 2  per-lane source-ready bits from the scoreboard.
REQ-010 SHALL provide port enq_is_store  in  ENQ_W  per-lane store flag.
REQ-011 SHALL provide port enq_ready  out  1  queue can accept ENQ_W entries.
REQ-012 SHALL provide port wake_valid  in  WAKE_W  wakeup strobes.
REQ-013 SHALL provide port wake_preg  in  WAKE_W x PRFNum  woken physical registers.
REQ-014 SHALL provide port lsu_busy  in  1  LSU cannot accept an issue this cycle.
REQ-015 SHALL provide port issue_valid  out  1  issue_uop is valid this cycle.
REQ-016 SHALL provide port issue_uop  out  UOPBundle  selected entry payload.
REQ-017 SHALL provide port count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 Entries SHALL be age-ordered and compacted: entry 0 oldest, valid entries contiguous from 0 to count-1.
REQ-019 enq_ready SHALL be 1 iff DEPTH - count >= ENQ_W, computed from registered count only, independent of issue.
REQ-020 Enqueue SHALL occur on a clock edge when enq_ready=1; the lanes set in enq_valid SHALL be written in lane order, with gaps squeezed out, at positions count - deq + k (k = rank among valid lanes), where deq is the same-cycle issue.
REQ-021 When enq_ready=0, enq_valid SHALL be ignored and nothing SHALL be written.
REQ-022 On issue, every entry above the issued index SHALL shift down by one on the same edge; enqueue and issue in the same cycle SHALL both take effect.
REQ-023 Each entry source-ready bit SHALL be set on the next edge when any wake_valid[j] has wake_preg[j] equal to that source; a set bit SHALL stay set until the entry leaves.
REQ-024 An enqueuing lane's ready bit SHALL be the OR of enq_src_rdy and a same-cycle wakeup match.
REQ-025 Entry i SHALL be eligible iff it is valid, both ready bits are set, lsu_busy=0, and the ordering rule holds.
REQ-026 ORDER_MODE 0: entry i SHALL be blocked if any valid entry j<i is a store (a store is issuable only as the oldest store, and no younger op passes it).
REQ-027 ORDER_MODE 1: only entry 0 SHALL be eligible.
REQ-028 Select SHALL choose the lowest-index eligible entry; issue_valid and issue_uop SHALL be combinational in the same cycle, and the entry SHALL be removed on the following edge.
REQ-029 Latency: an op enqueued with sources ready at edge N SHALL issue in cycle N+1 at the earliest; an op woken in cycle N SHALL issue in cycle N+1 at the earliest.
REQ-030 count next value SHALL be count + accepted enqueues - issue_valid, never exceeding DEPTH or going below 0.
REQ-031 flush SHALL invalidate all entries and set count=0 on the next edge, taking priority over same-cycle enqueue and issue; issue_valid SHALL still reflect pre-flush state in the flush cycle.

Reset
REQ-032 rst SHALL clear all entry valid and ready bits and set count=0; the resulting outputs SHALL be enq_ready=1, issue_valid=0, and issue_uop=0.
REQ-033 rst SHALL dominate flush, enqueue, and issue when asserted mid-operation.

Structure
REQ-034 UOPBundle, PRFNum, and the entry record {uop, rdy0, rdy1, is_store, valid} SHALL reside in the shared defines package.
REQ-035 A single sub-module lsu_iq_slot SHALL hold one entry together with its wakeup comparators and its shift/enqueue mux; the top SHALL instantiate DEPTH slots plus the select logic.

Verification
REQ-036 The bench SHALL cover: reset, then enqueue 2 loads with sources ready -> count=2, issue_valid=1 in the next cycle with entry 0's uop, count=1 after that.
REQ-037 The bench SHALL cover: load with op0 not ready (preg 12); wake_preg[2]=12 in cycle N -> issue in cycle N+1, not earlier.
REQ-038 The bench SHALL cover, in ORDER_MODE 0, a store (not ready) followed by a ready load -> no issue until the store is woken; the store issues first and the load issues on the next cycle.
REQ-039 The bench SHALL cover: DEPTH=8, ENQ_W=2, fill to 7 -> enq_ready=0; requests are dropped and count stays 7; one issue -> count=6 and enq_ready=1.
REQ-040 The bench SHALL cover: enqueue 2 with simultaneous issue of entry 1 at count=4 -> count=5; new ops land at indices 3 and 4, and age order is preserved.
REQ-041 The bench SHALL cover: flush asserted together with enq_valid=2'b11 -> count=0 and issue_valid=0 in the next cycle.
